// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared types and helpers for the crossbar arbiters.
// Holds the FSM state enum, default sizes and address field extraction.
package crossbar_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int N_IN_DEF  = 4;
   localparam int N_OUT_DEF = 4;
   localparam int ADDR_MAX  = 256;

   // Destination field idx of width w from a packed address vector.
   function automatic logic [7:0] dest_of(
      input logic [ADDR_MAX-1:0] addr,
      input int                  idx,
      input int                  w
   );
      logic [ADDR_MAX-1:0] s;
      s = addr >> (idx * w);
      return s[7:0] & 8'((1 << w) - 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: single-cycle rotate-priority encoder.
// Rotates a doubled request vector so the search starts at last+1.
module rr_pick #(
   parameter int N_IN  = 4,
   parameter int IDX_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  i_elig,
   input  logic [IDX_W-1:0] i_last,
   output logic             o_any,
   output logic [IDX_W-1:0] o_winner
);

   localparam int SW = IDX_W + 2;

   logic [2*N_IN-1:0] w_dbl;
   logic [2*N_IN-1:0] w_rot_full;
   logic [N_IN-1:0]   w_rot;
   logic [SW-1:0]     w_off;
   logic [SW-1:0]     w_sum;

   assign w_dbl      = {i_elig, i_elig};
   assign w_rot_full = w_dbl >> ({2'b00, i_last} + SW'(1));
   assign w_rot      = w_rot_full[N_IN-1:0];
   assign o_any      = |i_elig;

   // Lowest set bit of the rotated vector is the offset past last.
   always_comb begin
      w_off = '0;
      for (int k = N_IN - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = SW'(k);
      end
   end

   // Map the offset back to an absolute input index, modulo N_IN.
   always_comb begin
      w_sum = {2'b00, i_last} + SW'(1) + w_off;
      if (w_sum >= SW'(N_IN)) w_sum = w_sum - SW'(N_IN);
      o_winner = w_sum[IDX_W-1:0];
   end

endmodule

// File: rtl/crossbar_out_arbiter.sv
// crossbar_out_arbiter: per-output round-robin arbiter with packet lock.
// Grants one eligible input until release, or until the watchdog expires.
module crossbar_out_arbiter
   import crossbar_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int N_OUT   = N_OUT_DEF,
   parameter int DEST_W  = $clog2(N_OUT),
   parameter int IDX_W   = $clog2(N_IN),
   parameter int TIMEOUT = 255
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [DEST_W-1:0]      i_out_id,
   input  logic [N_IN-1:0]        i_requests,
   input  logic [N_IN*DEST_W-1:0] i_address,
   input  logic                   i_start,
   input  logic                   i_active,
   input  logic                   i_release,
   output logic                   o_grant_valid,
   output logic [IDX_W-1:0]       o_grant_idx,
   output logic [N_IN-1:0]        o_grant_onehot,
   output logic                   o_timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t            r_state, w_state;
   logic              r_valid, w_valid;
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic [N_IN-1:0]   r_onehot, w_onehot;
   logic              r_terr, w_terr;
   logic [IDX_W-1:0]  r_last, w_last;
   logic [WD_W-1:0]   r_wd, w_wd;

   logic [ADDR_MAX-1:0] w_addr_ext;
   logic [N_IN-1:0]     w_elig;
   logic                w_id_ok;
   logic                w_any;
   logic [IDX_W-1:0]    w_winner;

   assign w_addr_ext = ADDR_MAX'(i_address);
   assign w_id_ok    = (32'(i_out_id) < N_OUT);

   // An input is eligible when it requests and targets this output.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < N_IN; i++) begin
         w_elig[i] = i_requests[i] && w_id_ok &&
                     (dest_of(w_addr_ext, i, DEST_W) == 8'(i_out_id));
      end
   end

   rr_pick #(
      .N_IN  (N_IN),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_elig   (w_elig),
      .i_last   (r_last),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   // Next state: grant from IDLE, hold or release from BUSY.
   always_comb begin
      w_state  = r_state;
      w_valid  = r_valid;
      w_idx    = r_idx;
      w_onehot = r_onehot;
      w_terr   = 1'b0;
      w_last   = r_last;
      w_wd     = r_wd;
      case (r_state)
         IDLE: begin
            if (i_start && w_any) begin
               w_state  = BUSY;
               w_valid  = 1'b1;
               w_idx    = w_winner;
               w_onehot = N_IN'(1) << w_winner;
               w_last   = w_winner;
               w_wd     = '0;
            end
         end
         BUSY: begin
            if (i_release) begin
               w_state  = IDLE;
               w_valid  = 1'b0;
               w_onehot = '0;
            end else if (i_active) begin
               w_wd = '0;
            end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
               w_state  = IDLE;
               w_valid  = 1'b0;
               w_onehot = '0;
               w_terr   = 1'b1;
               w_wd     = WD_W'(TIMEOUT);
            end else begin
               w_wd = r_wd + WD_W'(1);
            end
         end
         default: w_state = IDLE;
      endcase
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= IDLE;
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_onehot <= '0;
         r_terr   <= 1'b0;
         r_last   <= IDX_W'(N_IN - 1);
         r_wd     <= '0;
      end else begin
         r_state  <= w_state;
         r_valid  <= w_valid;
         r_idx    <= w_idx;
         r_onehot <= w_onehot;
         r_terr   <= w_terr;
         r_last   <= w_last;
         r_wd     <= w_wd;
      end
   end

   assign o_grant_valid  = r_valid;
   assign o_grant_idx    = r_idx;
   assign o_grant_onehot = r_onehot;
   assign o_timeout_err  = r_terr;

endmodule

// File: tb/tb_crossbar_out_arbiter.sv
// tb_crossbar_out_arbiter: directed and randomized checks of the arbiter.
// A cycle-level reference model runs alongside the DUT.
module tb_crossbar_out_arbiter;

   localparam int N_IN    = 4;
   localparam int N_OUT   = 4;
   localparam int DEST_W  = 2;
   localparam int IDX_W   = 2;
   localparam int TIMEOUT = 8;

   logic                   clk;
   logic                   rst;
   logic [DEST_W-1:0]      out_id;
   logic [N_IN-1:0]        req;
   logic [N_IN*DEST_W-1:0] addr;
   logic                   start;
   logic                   active;
   logic                   rel;
   logic                   gv;
   logic [IDX_W-1:0]       gidx;
   logic [N_IN-1:0]        goh;
   logic                   terr;

   int tests;
   int fails;

   int m_busy;
   int m_idx;
   int m_last;
   int m_wd;
   int m_terr;

   crossbar_out_arbiter #(
      .N_IN    (N_IN),
      .N_OUT   (N_OUT),
      .DEST_W  (DEST_W),
      .IDX_W   (IDX_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_out_id       (out_id),
      .i_requests     (req),
      .i_address      (addr),
      .i_start        (start),
      .i_active       (active),
      .i_release      (rel),
      .o_grant_valid  (gv),
      .o_grant_idx    (gidx),
      .o_grant_onehot (goh),
      .o_timeout_err  (terr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 0;
      m_idx  = 0;
      m_last = N_IN - 1;
      m_wd   = 0;
      m_terr = 0;
   endtask

   task automatic model_step();
      int j;
      int d;
      if (!rst) begin
         model_reset();
         return;
      end
      m_terr = 0;
      if (m_busy == 0) begin
         if (start) begin
            for (int k = 1; k <= N_IN; k++) begin
               j = (m_last + k) % N_IN;
               d = int'((addr >> (j * DEST_W)) & 8'h3);
               if (req[j] && d == int'(out_id) && m_busy == 0) begin
                  m_busy = 1;
                  m_idx  = j;
                  m_last = j;
                  m_wd   = 0;
               end
            end
         end
      end else if (rel) begin
         m_busy = 0;
      end else if (active) begin
         m_wd = 0;
      end else begin
         m_wd = m_wd + 1;
         if (m_wd >= TIMEOUT) begin
            m_busy = 0;
            m_terr = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      start  = 1'b0;
      active = 1'b0;
      rel    = 1'b0;
      req    = '0;
      addr   = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      out_id = 2'd0;
      do_reset();
      tests++;
      if (gv !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid got %b want 0", gv);
      end
      tests++;
      if (gidx !== 2'd0) begin
         fails++;
         $display("FAIL reset_idx got %0d want 0", gidx);
      end
      tests++;
      if (goh !== 4'b0000) begin
         fails++;
         $display("FAIL reset_onehot got %b want 0000", goh);
      end
      tests++;
      if (terr !== 1'b0) begin
         fails++;
         $display("FAIL reset_terr got %b want 0", terr);
      end
   endtask

   task automatic test_single();
      do_reset();
      out_id = 2'd2;
      req    = 4'b0100;
      addr   = 8'h20;
      start  = 1'b1;
      active = 1'b1;
      tick();
      tests++;
      if (gv !== 1'b1 || gidx !== 2'd2 || goh !== 4'b0100) begin
         fails++;
         $display("FAIL single_grant got v=%b i=%0d oh=%b want v=1 i=2 oh=0100",
                  gv, gidx, goh);
      end
      rel = 1'b1;
      req = 4'b1010;
      addr = 8'b10_00_10_00;
      tick();
      rel = 1'b0;
      tick();
      tests++;
      if (gv !== 1'b1 || gidx !== 2'd3) begin
         fails++;
         $display("FAIL single_next_after_last2 got v=%b i=%0d want v=1 i=3",
                  gv, gidx);
      end
   endtask

   task automatic test_fairness();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      do_reset();
      out_id = 2'd1;
      req    = 4'b1111;
      addr   = 8'b01_01_01_01;
      start  = 1'b1;
      active = 1'b1;
      for (int g = 0; g < 5; g++) begin
         tick();
         tests++;
         if (gv !== 1'b1 || int'(gidx) != exp_seq[g]) begin
            fails++;
            $display("FAIL fair_grant%0d got v=%b i=%0d want v=1 i=%0d",
                     g, gv, gidx, exp_seq[g]);
         end
         rel = 1'b1;
         tick();
         rel = 1'b0;
         tests++;
         if (gv !== 1'b0 || goh !== 4'b0000) begin
            fails++;
            $display("FAIL fair_bubble%0d got v=%b oh=%b want v=0 oh=0000",
                     g, gv, goh);
         end
      end
   endtask

   task automatic test_filter();
      int bad;
      do_reset();
      out_id = 2'd3;
      req    = 4'b1111;
      addr   = 8'b00_11_11_00;
      start  = 1'b1;
      active = 1'b1;
      bad    = 0;
      for (int g = 0; g < 6; g++) begin
         tick();
         if (gv !== 1'b1 || int'(gidx) != ((g % 2 == 0) ? 1 : 2)) bad++;
         rel = 1'b1;
         tick();
         rel = 1'b0;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL filter_alternate got %0d bad grants want 0", bad);
      end
   endtask

   task automatic test_lock();
      int bad;
      do_reset();
      out_id = 2'd1;
      req    = 4'b0010;
      addr   = 8'b00_00_01_00;
      start  = 1'b1;
      active = 1'b1;
      tick();
      req  = 4'b0001;
      addr = 8'b00_00_10_01;
      bad  = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (gv !== 1'b1 || gidx !== 2'd1 || goh !== 4'b0010) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL lock_hold got %0d bad cycles want 0", bad);
      end
      start = 1'b0;
      rel   = 1'b1;
      tick();
      rel = 1'b0;
      tests++;
      if (gv !== 1'b0 || gidx !== 2'd1 || goh !== 4'b0000) begin
         fails++;
         $display("FAIL lock_release got v=%b i=%0d oh=%b want v=0 i=1 oh=0000",
                  gv, gidx, goh);
      end
   endtask

   task automatic test_watchdog();
      int first;
      int fall;
      int fired;
      do_reset();
      out_id = 2'd0;
      req    = 4'b0001;
      addr   = 8'h00;
      start  = 1'b1;
      active = 1'b0;
      tick();
      start = 1'b0;
      first = 0;
      fall  = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (terr === 1'b1 && first == 0) first = e;
         if (gv !== 1'b1 && fall == 0) fall = e;
      end
      tests++;
      if (first != TIMEOUT) begin
         fails++;
         $display("FAIL wd_pulse_edge got %0d want %0d", first, TIMEOUT);
      end
      tests++;
      if (fall != TIMEOUT) begin
         fails++;
         $display("FAIL wd_valid_fall got %0d want %0d", fall, TIMEOUT);
      end
      tests++;
      if (terr !== 1'b0) begin
         fails++;
         $display("FAIL wd_pulse_width got %b want 0", terr);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e < TIMEOUT; e++) tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
      tests++;
      if (terr !== 1'b0 || gv !== 1'b0) begin
         fails++;
         $display("FAIL wd_release_wins got terr=%b v=%b want terr=0 v=0",
                  terr, gv);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      fired = 0;
      for (int c = 1; c <= 40; c++) begin
         active = (c % 5 == 0);
         tick();
         if (terr === 1'b1 || gv !== 1'b1) fired++;
      end
      active = 1'b0;
      tests++;
      if (fired != 0) begin
         fails++;
         $display("FAIL wd_keepalive got %0d bad cycles want 0", fired);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_id = 2'd0;
      req    = 4'b0001;
      addr   = 8'h00;
      start  = 1'b1;
      active = 1'b1;
      tick();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      tests++;
      if (gv !== 1'b0 || goh !== 4'b0000) begin
         fails++;
         $display("FAIL async_drop got v=%b oh=%b want v=0 oh=0000", gv, goh);
      end
      tick();
      rst  = 1'b1;
      req  = 4'b1001;
      addr = 8'h00;
      tick();
      tests++;
      if (gv !== 1'b1 || gidx !== 2'd0) begin
         fails++;
         $display("FAIL async_first_grant got v=%b i=%0d want v=1 i=0", gv, gidx);
      end
   endtask

   task automatic test_random();
      int bad;
      logic [N_IN-1:0] exp_oh;
      do_reset();
      out_id = 2'($urandom_range(0, 3));
      bad = 0;
      for (int c = 0; c < 400; c++) begin
         req    = 4'($urandom);
         addr   = 8'($urandom);
         start  = ($urandom_range(0, 3) != 0);
         active = ($urandom_range(0, 3) == 0);
         rel    = ($urandom_range(0, 15) == 0);
         tick();
         exp_oh = (m_busy != 0) ? (4'b0001 << m_idx) : 4'b0000;
         if (gv !== (m_busy != 0) || int'(gidx) != m_idx ||
             goh !== exp_oh || terr !== (m_terr != 0)) begin
            bad++;
            if (bad <= 5)
               $display("FAIL rand_cycle%0d got v=%b i=%0d oh=%b t=%b want v=%0d i=%0d oh=%b t=%0d",
                        c, gv, gidx, goh, terr, m_busy, m_idx, exp_oh, m_terr);
         end
      end
      rel = 1'b0;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL rand_model got %0d bad cycles want 0", bad);
      end
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst    = 1'b0;
      out_id = '0;
      req    = '0;
      addr   = '0;
      start  = 1'b0;
      active = 1'b0;
      rel    = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_filter();
      test_lock();
      test_watchdog();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/crossbar_out_arbiter.md
# crossbar_out_arbiter

Parametrised per-output round-robin arbiter for the crossbar switch. One instance sits on each output port. It selects one input whose request targets that port and locks the grant until the output state machine signals end of packet. It scans all eligible inputs in a single cycle rather than polling one input per cycle, and adds a watchdog that forces release of a stalled grant.

## Interface
Parameters:
- N_IN, 4, number of crossbar inputs (≥2)
- N_OUT, 4, number of crossbar outputs (≥2)
- DEST_W, $clog2(N_OUT), width of one destination address field
- IDX_W, $clog2(N_IN), width of grant index
- TIMEOUT, 255, idle cycles while granted before forced release (≥1)

Ports:
- clk  in  1  system clock; rising edge only
- reset  in  1  asynchronous, active-low reset
- out_id  in  DEST_W  index of the output this arbiter serves; static
- requests  in  N_IN  per-input request flags
- address  in  N_IN*DEST_W  destination per input; input i at bits [i*DEST_W +: DEST_W]
- start  in  1  output state machine is ready to accept a new grant
- active  in  1  a data beat moved on this output this cycle
- release  in  1  end of packet; drop the grant
- grant_valid  out  1  grant held
- grant_idx  out  IDX_W  granted input index
- grant_onehot  out  N_IN  one-hot copy of grant_idx; all zero when not granted
- timeout_err  out  1  one-cycle pulse on watchdog-forced release

## Operation
- Eligibility is combinational: elig[i] = requests[i] && address slice i == out_id.
- last is a register holding the index of the most recent grant. Search order is last+1, last+2, … with wrap modulo N_IN. The first eligible input in that order wins.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If start && |elig: register the winner into grant_idx and grant_onehot, set grant_valid=1, set last=winner, clear the watchdog, go to BUSY.
  - Otherwise stay in IDLE with outputs unchanged. release and active are ignored.
- BUSY:
  - Grant is locked. Changes to requests or address of the granted input do not affect it.
  - start is ignored.
  - On release: go to IDLE, grant_valid=0, grant_onehot=0. grant_idx keeps its value.
  - Otherwise, if active: clear the watchdog.
  - Otherwise, increment the watchdog. When it would reach TIMEOUT, force the release and pulse timeout_err for that cycle.
- release and watchdog expiry in the same cycle: treated as a normal release, timeout_err=0.
- Watchdog width is $clog2(TIMEOUT+1). It saturates, never wraps.
- Reset values (asynchronous, on reset=0):
  - state=IDLE
  - grant_valid=0, grant_idx=0, grant_onehot=0, timeout_err=0
  - last=N_IN-1, so input 0 has first priority after reset
  - watchdog=0
- Reset asserted mid-packet drops the grant immediately. No release is required.
- out_id ≥ N_OUT matches no address, so the block never grants.

## Timing
- Grant latency: grant_valid rises on the first clk edge where IDLE && start && |elig. There is no combinational path from requests to outputs.
- All outputs are registered.
- Release to IDLE takes one edge. The earliest re-grant is on the following edge, which gives a minimum one-cycle bubble between packets, even if start is held high.
- Watchdog: with active held low after the grant, timeout_err pulses and grant_valid falls on the TIMEOUT-th edge after the grant edge.
- last updates only on a grant. A forced release does not advance the pointer again.

## Structure
- The shared package crossbar_pkg holds:
  - the state enum (IDLE, BUSY)
  - the default N_IN / N_OUT constants
  - a function extracting destination field i from a packed address vector
- The natural sub-module is rr_pick: a combinational rotate-priority encoder.
  - Inputs: elig[N_IN], last[IDX_W].
  - Outputs: any, winner[IDX_W].
  - Implemented by doubling the request vector and masking, so there is no loop-carried priority chain over N_IN² terms.
- The top level contains the eligibility compare, the state machine, the last pointer and the watchdog.

## Test plan
- Reset then single requester: N_IN=4, out_id=2, requests=0100, address input2=2, start=1. grant_idx=2 and grant_onehot=0100 on the next edge; last=2.
- Fairness: all four inputs request out_id=1. Pulse release each packet with start held high. Grant order is 0,1,2,3,0, with a one-cycle bubble between grants.
- Address filtering: requests=1111, addresses 0,3,3,0, out_id=3. Only inputs 1 and 2 are granted, in alternation. Inputs 0 and 3 are never granted.
- Lock: after grant to input 1, drop requests[1] and change address[1]. grant_valid stays 1 and grant_idx stays 1 until release.
- Watchdog: TIMEOUT=8, grant then hold active=0. timeout_err pulses exactly 8 edges after the grant and grant_valid falls. With active toggled every 5 cycles, timeout_err never fires.
- Async reset mid-BUSY: reset falls between edges. grant_valid=0 immediately. After reset rises, the first grant goes to input 0 when inputs 0 and 3 both request.
